// File: rtl/div_pkg.sv
// Shared types and constants for the pipelined integer divider.
package div_pkg;

    // Widths the stage payload is built with; the top-level parameters must agree.
    localparam int DIV_DW     = 32;
    localparam int DIV_N_PIPE = 8;
    localparam int DIV_TW     = 4;

    // Most-negative two's-complement value at DIV_DW bits.
    localparam logic [DIV_DW-1:0] DIV_MIN = {1'b1, {(DIV_DW-1){1'b0}}};

    // Everything that travels down the iteration pipeline with one operation.
    typedef struct packed {
        logic [DIV_DW-1:0] rem;     // partial remainder, starts as |A|
        logic [DIV_DW-1:0] quo;     // partial quotient, filled MSB first
        logic [DIV_DW-1:0] b_abs;   // |B|
        logic              q_sign;  // negate quotient at the end
        logic              r_sign;  // negate remainder at the end
        logic              dz;      // divisor was zero
        logic              ovf;     // MIN / -1 in signed mode
        logic              sgn;     // operation was signed
        logic [DIV_DW-1:0] a_orig;  // untouched dividend for forced results
        logic [DIV_TW-1:0] tag;
    } div_stage_t;

    // True when the configuration can be built: whole number of bits per
    // stage, legal width range, and widths matching the payload struct.
    function automatic bit div_cfg_ok(input int dw, input int n_pipe, input int tw);
        return (n_pipe > 0) && (dw % n_pipe == 0) && (dw % 2 == 0) &&
               (dw >= 8) && (dw <= 64) && (dw == DIV_DW) && (tw == DIV_TW);
    endfunction

endpackage

// File: rtl/div_pipe_if.sv
// Request/result bundle of the divider.
// Handshake: start_i is a one-cycle request strobe with no ready; the divider
// takes one operation every cycle. valid_o is a one-cycle result strobe with
// no backpressure; the consumer must take it in that cycle.
interface div_pipe_if import div_pkg::*; #(
    parameter int DW = DIV_DW,
    parameter int TW = DIV_TW
);
    logic          start_i;
    logic          signed_i;
    logic [DW-1:0] A_i;
    logic [DW-1:0] B_i;
    logic [TW-1:0] tag_i;
    logic          flush_i;
    logic          busy_o;
    logic          valid_o;
    logic [DW-1:0] quotient_o;
    logic [DW-1:0] remainder_o;
    logic [TW-1:0] tag_o;
    logic          dz_o;
    logic          ovf_o;

    modport master (
        output start_i, signed_i, A_i, B_i, tag_i, flush_i,
        input  busy_o, valid_o, quotient_o, remainder_o, tag_o, dz_o, ovf_o
    );

    modport slave (
        input  start_i, signed_i, A_i, B_i, tag_i, flush_i,
        output busy_o, valid_o, quotient_o, remainder_o, tag_o, dz_o, ovf_o
    );
endinterface

// File: rtl/div_stage.sv
// One iteration stage: K restoring steps followed by a pipeline register.
module div_stage import div_pkg::*; #(
    parameter int DW  = DIV_DW,
    parameter int K   = 4,
    parameter int IDX = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       valid_i,
    input  div_stage_t d_i,
    output logic       valid_o,
    output div_stage_t d_o
);

    logic [2*DW-1:0] rem_w;
    logic [2*DW-1:0] div_w;
    div_stage_t      d_n;

    // Resolve quotient bits DW-1-IDX*K down to DW-(IDX+1)*K by comparing the
    // remainder against |B| shifted to each bit position at double width.
    always_comb begin
        d_n   = d_i;
        rem_w = {{DW{1'b0}}, d_i.rem};
        div_w = '0;
        for (int k = 0; k < K; k++) begin
            div_w = {{DW{1'b0}}, d_i.b_abs} << (DW - 1 - IDX*K - k);
            if (rem_w >= div_w) begin
                rem_w                       = rem_w - div_w;
                d_n.quo[DW - 1 - IDX*K - k] = 1'b1;
            end
        end
        d_n.rem = rem_w[DW-1:0];
    end

    // Valid bit advances unless flushed; cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i & ~flush_i;
        end
    end

    // Payload register, loaded only when an operation is present.
    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            d_o <= d_n;
        end
    end

endmodule

// File: rtl/div_pipe.sv
// Fully pipelined signed/unsigned restoring divider: input stage, N_PIPE
// iteration stages, sign-fix register and output register.
module div_pipe import div_pkg::*; #(
    parameter int DW     = DIV_DW,
    parameter int N_PIPE = DIV_N_PIPE,
    parameter int TW     = DIV_TW
) (
    input logic       clk_i,
    input logic       rst_ni,
    div_pipe_if.slave bus
);

    localparam int K = DW / N_PIPE;

    if (!div_cfg_ok(DW, N_PIPE, TW)) begin : g_cfg_err
        $error("div_pipe: unsupported DW/N_PIPE/TW combination");
    end

    logic          a_neg;
    logic          b_neg;
    div_stage_t    s0_n;
    div_stage_t    s0_q;
    logic          s0_valid_q;

    logic          chain_v [0:N_PIPE];
    div_stage_t    chain_d [0:N_PIPE];
    logic          busy;

    logic [DW-1:0] fix_q_n;
    logic [DW-1:0] fix_r_n;
    logic          post_valid_q;
    logic [DW-1:0] post_q_q;
    logic [DW-1:0] post_r_q;
    logic [TW-1:0] post_tag_q;
    logic          post_dz_q;
    logic          post_ovf_q;

    logic          out_valid_q;
    logic [DW-1:0] out_q_q;
    logic [DW-1:0] out_r_q;
    logic [TW-1:0] out_tag_q;
    logic          out_dz_q;
    logic          out_ovf_q;

    // Input stage: magnitudes, result signs and exception flags.
    always_comb begin
        a_neg         = bus.signed_i & bus.A_i[DW-1];
        b_neg         = bus.signed_i & bus.B_i[DW-1];
        s0_n          = '0;
        s0_n.rem      = a_neg ? -bus.A_i : bus.A_i;
        s0_n.b_abs    = b_neg ? -bus.B_i : bus.B_i;
        s0_n.q_sign   = a_neg ^ b_neg;
        s0_n.r_sign   = a_neg;
        s0_n.dz       = (bus.B_i == '0);
        s0_n.ovf      = bus.signed_i & (bus.A_i == DIV_MIN) & (&bus.B_i);
        s0_n.sgn      = bus.signed_i;
        s0_n.a_orig   = bus.A_i;
        s0_n.tag      = bus.tag_i;
    end

    // Input-stage valid; flush wins over a simultaneous start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_valid_q <= 1'b0;
        end else begin
            s0_valid_q <= bus.start_i & ~bus.flush_i;
        end
    end

    // Input-stage payload, captured on every start.
    always_ff @(posedge clk_i) begin
        if (bus.start_i) begin
            s0_q <= s0_n;
        end
    end

    assign chain_v[0] = s0_valid_q;
    assign chain_d[0] = s0_q;

    for (genvar g = 0; g < N_PIPE; g++) begin : g_stage
        div_stage #(
            .DW  (DW),
            .K   (K),
            .IDX (g)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (bus.flush_i),
            .valid_i (chain_v[g]),
            .d_i     (chain_d[g]),
            .valid_o (chain_v[g+1]),
            .d_o     (chain_d[g+1])
        );
    end

    // Busy while any operation sits in the input or iteration stages.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= N_PIPE; i++) begin
            busy = busy | chain_v[i];
        end
    end

    // Sign correction with forced results for divide-by-zero and overflow.
    always_comb begin
        fix_q_n = chain_d[N_PIPE].q_sign ? -chain_d[N_PIPE].quo : chain_d[N_PIPE].quo;
        fix_r_n = chain_d[N_PIPE].r_sign ? -chain_d[N_PIPE].rem : chain_d[N_PIPE].rem;
        if (chain_d[N_PIPE].dz) begin
            fix_q_n = '1;
            fix_r_n = chain_d[N_PIPE].a_orig;
        end else if (chain_d[N_PIPE].ovf & chain_d[N_PIPE].sgn) begin
            fix_q_n = chain_d[N_PIPE].a_orig;
            fix_r_n = '0;
        end
    end

    // Sign-fix stage valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            post_valid_q <= 1'b0;
        end else begin
            post_valid_q <= chain_v[N_PIPE] & ~bus.flush_i;
        end
    end

    // Sign-fix stage payload.
    always_ff @(posedge clk_i) begin
        if (chain_v[N_PIPE]) begin
            post_q_q   <= fix_q_n;
            post_r_q   <= fix_r_n;
            post_tag_q <= chain_d[N_PIPE].tag;
            post_dz_q  <= chain_d[N_PIPE].dz;
            post_ovf_q <= chain_d[N_PIPE].ovf & chain_d[N_PIPE].sgn & ~chain_d[N_PIPE].dz;
        end
    end

    // Output register: pulses valid, holds the last result otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
            out_r_q     <= '0;
            out_tag_q   <= '0;
            out_dz_q    <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= post_valid_q & ~bus.flush_i;
            if (post_valid_q & ~bus.flush_i) begin
                out_q_q   <= post_q_q;
                out_r_q   <= post_r_q;
                out_tag_q <= post_tag_q;
                out_dz_q  <= post_dz_q;
                out_ovf_q <= post_ovf_q;
            end
        end
    end

    assign bus.busy_o      = busy;
    assign bus.valid_o     = out_valid_q;
    assign bus.quotient_o  = out_q_q;
    assign bus.remainder_o = out_r_q;
    assign bus.tag_o       = out_tag_q;
    assign bus.dz_o        = out_dz_q;
    assign bus.ovf_o       = out_ovf_q;

endmodule

// File: tb/tb_div_pipe.sv
// Self-checking bench for div_pipe: directed corner cases, streaming,
// flush, mid-stream reset and a randomized mix against a reference model.
module tb_div_pipe;

    localparam int W = 70;   // {tag[3:0], dz, ovf, quotient[31:0], remainder[31:0]}
    typedef logic [W-1:0] vec_t;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_pipe_if #(.DW(32), .TW(4)) bus ();

    div_pipe #(
        .DW     (32),
        .N_PIPE (8),
        .TW     (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // ---------------- scoreboard state ----------------
    vec_t exp_q[$];
    int   exp_t[$];
    vec_t last_out;
    vec_t mon_exp;
    int   mon_t;
    logic busy_exp;
    int   edges   = 0;
    int   n_vec   = 0;
    int   n_bad   = 0;

    task automatic check(input string name, input vec_t got, input vec_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t pack(input logic [3:0] tag, input logic dz, input logic ovf,
                                  input logic [31:0] q, input logic [31:0] r);
        return {tag, dz, ovf, q, r};
    endfunction

    function automatic vec_t obs();
        return {bus.tag_o, bus.dz_o, bus.ovf_o, bus.quotient_o, bus.remainder_o};
    endfunction

    // Reference: plain integer division, truncating toward zero.
    function automatic vec_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] tag);
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
        dz  = 1'b0;
        ovf = 1'b0;
        sa  = a;
        sb  = b;
        if (b == 32'd0) begin
            dz = 1'b1;
            q  = 32'hFFFF_FFFF;
            r  = a;
        end else if (sgn && a == MIN32 && b == 32'hFFFF_FFFF) begin
            ovf = 1'b1;
            q   = a;
            r   = 32'd0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return pack(tag, dz, ovf, q, r);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input bit st, input bit sgn, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] tag, input bit fl);
        @(negedge clk);
        #1;
        bus.start_i  = st;
        bus.signed_i = sgn;
        bus.A_i      = a;
        bus.B_i      = b;
        bus.tag_i    = tag;
        bus.flush_i  = fl;
    endtask

    // Issue with the model's expectation; a start under flush is dropped.
    task automatic drive(input bit st, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag, input bit fl);
        set_inputs(st, sgn, a, b, tag, fl);
        if (st && !fl) begin
            exp_q.push_back(model(sgn, a, b, tag));
            exp_t.push_back(edges + 11);
        end
    endtask

    // Issue with a hand-derived expectation.
    task automatic drive_exp(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] tag, input vec_t exp);
        set_inputs(1'b1, sgn, a, b, tag, 1'b0);
        exp_q.push_back(exp);
        exp_t.push_back(edges + 11);
    endtask

    task automatic idle();
        set_inputs(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic rand_op(output bit sgn, output logic [31:0] a, output logic [31:0] b);
        int cat;
        cat = $urandom_range(0, 9);
        sgn = 1'($urandom_range(0, 1));
        a   = $urandom;
        b   = $urandom;
        case (cat)
            0: b = 32'd0;
            1: begin a = MIN32; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            3: a = $urandom_range(0, 100);
            4: b = -32'($urandom_range(1, 15));
            default: ;
        endcase
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle();
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", vec_t'(exp_q.size()), vec_t'(0));
            exp_q.delete();
            exp_t.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_t.delete();
        last_out = '0;
        #1;
        check("rst_async_valid", vec_t'(bus.valid_o), vec_t'(1'b0));
        check("rst_async_busy", vec_t'(bus.busy_o), vec_t'(1'b0));
        check("rst_async_out", obs(), vec_t'(0));
        bus.start_i  = 1'b1;
        bus.signed_i = 1'b0;
        bus.A_i      = 32'd77;
        bus.B_i      = 32'd5;
        bus.tag_i    = 4'd9;
        repeat (3) @(negedge clk);
        #1;
        bus.start_i = 1'b0;
        rst_n       = 1'b1;
    endtask

    // ---------------- cycle counter and flush tracking ----------------
    always @(posedge clk) begin
        edges <= edges + 1;
        if (rst_n && bus.flush_i) begin
            exp_q.delete();
            exp_t.delete();
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_t.size() > 0 && exp_t[0] < edges) begin
                check("missing_valid", vec_t'(edges), vec_t'(exp_t[0]));
                void'(exp_q.pop_front());
                void'(exp_t.pop_front());
            end
            // An operation keeps the unit busy until it is one cycle from its result.
            busy_exp = 1'b0;
            foreach (exp_t[i]) begin
                if (exp_t[i] - edges >= 2) busy_exp = 1'b1;
            end
            check("busy", vec_t'(bus.busy_o), vec_t'(busy_exp));
            if (bus.valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", vec_t'(bus.valid_o), vec_t'(1'b0));
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_t   = exp_t.pop_front();
                    check("result", obs(), mon_exp);
                    check("latency", vec_t'(edges), vec_t'(mon_t));
                    last_out = mon_exp;
                end
            end else begin
                check("hold", obs(), last_out);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;

        bus.start_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.A_i      = '0;
        bus.B_i      = '0;
        bus.tag_i    = '0;
        bus.flush_i  = 1'b0;
        last_out     = '0;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;
        #2;
        check("reset_valid", vec_t'(bus.valid_o), vec_t'(1'b0));
        check("reset_busy", vec_t'(bus.busy_o), vec_t'(1'b0));
        check("reset_out", obs(), vec_t'(0));
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Directed corner cases, back to back.
        drive_exp(1'b0, 32'd100, 32'd7, 4'd3, pack(4'd3, 1'b0, 1'b0, 32'd14, 32'd2));
        drive_exp(1'b1, 32'hFFFF_FFF9, 32'd2, 4'd4,
                  pack(4'd4, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF));
        drive_exp(1'b1, 32'd7, 32'hFFFF_FFFE, 4'd5,
                  pack(4'd5, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd1));
        drive_exp(1'b0, 32'd5, 32'd0, 4'd6, pack(4'd6, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd5));
        drive_exp(1'b1, 32'd5, 32'd0, 4'd7, pack(4'd7, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd5));
        drive_exp(1'b1, MIN32, 32'hFFFF_FFFF, 4'd8, pack(4'd8, 1'b0, 1'b1, MIN32, 32'd0));
        drive_exp(1'b0, MIN32, 32'hFFFF_FFFF, 4'd9, pack(4'd9, 1'b0, 1'b0, 32'd0, MIN32));
        drive_exp(1'b0, 32'hFFFF_FFFF, 32'd1, 4'd10,
                  pack(4'd10, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0));
        drive_exp(1'b1, MIN32, 32'd1, 4'd11, pack(4'd11, 1'b0, 1'b0, MIN32, 32'd0));
        drain();

        // Streaming: 20 back-to-back operations.
        for (int i = 0; i < 20; i++) begin
            rand_op(sgn, a, b);
            drive(1'b1, sgn, a, b, 4'(i), 1'b0);
        end
        drain();

        // Flush with five in flight; a start under flush is dropped; the next one survives.
        for (int i = 0; i < 5; i++) begin
            rand_op(sgn, a, b);
            drive(1'b1, sgn, a, b, 4'(i), 1'b0);
        end
        drive(1'b1, 1'b0, 32'd50, 32'd3, 4'd14, 1'b1);
        drive(1'b1, 1'b0, 32'd1000, 32'd9, 4'd12, 1'b0);
        drain();

        // Reset pulsed mid-stream, then a fresh operation.
        for (int i = 0; i < 6; i++) begin
            rand_op(sgn, a, b);
            drive(1'b1, sgn, a, b, 4'(i), 1'b0);
        end
        pulse_reset();
        drive(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 4'd13, 1'b0);
        drain();

        // Randomized mix with idle gaps and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            rand_op(sgn, a, b);
            drive(1'($urandom_range(0, 9) < 7), sgn, a, b, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 29) == 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
